minutes_hours_counter: RTL
==========================

Name: minutes_hours_counter

Overview:
Downstream stage of seconds_counter. It consumes the one-cycle tick_minute pulse and maintains minutes (0-59) and hours (0-23) of a 24-hour clock. It also produces 12-hour display values and hour/day carry pulses. Time can be preset through a validated load port; an invalid load is rejected and flagged.

Parameters:
MIN_W, 6, minutes width.
HR_W, 5, hours width.
MIN_MAX, 59, last minute value before wrap.
HR_MAX, 23, last hour value before wrap.

Ports:
clk  in  1  system clock, all state updates on rising edge.
rst  in  1  synchronous, active-high reset.
tick_minute  in  1  one-cycle pulse from seconds_counter, marks a 59->0 seconds rollover.
count_en  in  1  when low, tick_minute is ignored.
load  in  1  one-cycle request to preset time.
load_min  in  MIN_W  preset minutes value.
load_hr  in  HR_W  preset hours value (24h).
minutes  out  MIN_W  current minutes, registered.
hours  out  HR_W  current hours in 24h format, registered.
hours_12  out  4  12-hour display value 1-12, combinational from hours.
pm  out  1  high for hours 12-23, combinational from hours.
tick_hour  out  1  one-cycle pulse, registered.
tick_day  out  1  one-cycle pulse, registered.
load_err  out  1  one-cycle pulse, registered.

Behaviour:
- Reset:
  - rst=1 at a clk edge sets minutes=0, hours=0, tick_hour=0, tick_day=0, load_err=0. This gives hours_12=12, pm=0.
  - Reset overrides load and tick in the same cycle.
  - Reset mid-count clears state on that edge; there is no partial update.
- Count: tick_minute=1 and count_en=1 (and no accepted load) on an edge:
  - minutes < MIN_MAX: minutes+1.
  - minutes == MIN_MAX: minutes=0 and tick_hour=1 on that same edge. hours+1, or hours=0 if hours == HR_MAX.
  - 23:59 -> 00:00: tick_hour=1 and tick_day=1 together.
- Pulses:
  - tick_hour, tick_day and load_err are high for exactly one cycle, then return to 0 on the next edge unless retriggered.
  - Back-to-back tick_minute pulses (every cycle) are counted each cycle.
- Load:
  - load=1 with load_min <= MIN_MAX and load_hr <= HR_MAX: minutes=load_min, hours=load_hr on that edge.
  - Accepted load takes priority; a coincident tick_minute is dropped.
  - No tick_hour or tick_day is generated by a load, even when the value lands on 0.
  - load=1 with any field out of range: registers unchanged, load_err=1 for one cycle. A coincident valid tick is still counted normally.
  - load works regardless of count_en.
- 12-hour conversion:
  - hours 0 -> 12, pm=0.
  - hours 1-11 -> same value, pm=0.
  - hours 12 -> 12, pm=1.
  - hours 13-23 -> hours-12, pm=1.
- Widths: all comparisons are unsigned. Out-of-range internal values cannot occur, because load is validated and wrap is explicit.

Decomposition:
- Shared package clock_pkg holds:
  - MIN_W, HR_W, SEC_W=6.
  - MIN_MAX=59, HR_MAX=23, SEC_MAX=59.
  - time_t struct {hours, minutes}, used by seconds_counter and future alarm/compare blocks.
- One natural sub-module: hour_fmt_12h, a combinational 24h -> (hours_12, pm) converter. It is reused by any later display block.
- Counter and load logic stay in minutes_hours_counter.

Test Plan:
1. Reset then 60 tick_minute pulses with count_en=1 -> minutes 0..59 then 0, hours=1, tick_hour high exactly once on the 60th tick edge.
2. load 23:59, then one tick -> minutes=0, hours=0, tick_hour=1 and tick_day=1 for one cycle, hours_12=12, pm=0.
3. load 12:30 and check pm=1, hours_12=12; then load 13:05 and check hours_12=1, pm=1; then load 0:00 and check tick_hour=0.
4. load_min=60 (or load_hr=24) with tick_minute in the same cycle, from 10:10 -> load_err pulses once, time becomes 10:11. Then valid load 5:00 with coincident tick -> 5:00, tick dropped.
5. count_en=0 with 10 ticks -> no change; re-enable -> counting resumes from the held value.
6. Random-interval ticks with rst pulsed at random points (10 iterations) -> every rst edge yields 00:00 with all pulses 0 on the next cycle; a tick coincident with rst is ignored.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared time-of-day constants and types for the clock datapath
// (seconds_counter, minutes_hours_counter, display and alarm blocks).
package clock_pkg;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HR_W    = 5;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  // First hour of the afternoon in 24h format; also the 12h display span.
  localparam int NOON_HR = 12;

  typedef struct packed {
    logic [HR_W-1:0]  hours;
    logic [MIN_W-1:0] minutes;
  } time_t;

endpackage : clock_pkg

// File: rtl/hour_fmt_12h.sv
// Combinational 24h -> 12h display converter: 0 -> 12 AM, 12 -> 12 PM,
// 13..23 -> 1..11 PM. Shared by any block that drives a 12h display.
module hour_fmt_12h
#(
  parameter int HR_W = 5
) (
  input  logic [HR_W-1:0] hours,
  output logic [3:0]      hours_12,
  output logic            pm
);
  import clock_pkg::*;

  localparam logic [HR_W-1:0] NOON = HR_W'(NOON_HR);

  // Fold the 24h value onto 1..12 and flag the afternoon half.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    hours_12 = 4'(NOON_HR);
    pm       = 1'b0;
    if (hours == '0) begin
      hours_12 = 4'(NOON_HR);
    end else if (hours < NOON) begin
      hours_12 = 4'(hours);
    end else if (hours == NOON) begin
      hours_12 = 4'(NOON_HR);
      pm       = 1'b1;
    end else begin
      hours_12 = 4'(hours - NOON);
      pm       = 1'b1;
    end
  end

endmodule : hour_fmt_12h

// File: rtl/minutes_hours_counter.sv
// Minutes/hours stage of the clock. Counts tick_minute pulses into a 24h
// time, emits hour/day carry pulses, accepts range-checked presets and
// reports rejected presets with a one-cycle load_err pulse.
module minutes_hours_counter
#(
  parameter int MIN_W   = 6,
  parameter int HR_W    = 5,
  parameter int MIN_MAX = 59,
  parameter int HR_MAX  = 23
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_minute,
  input  logic             count_en,
  input  logic             load,
  input  logic [MIN_W-1:0] load_min,
  input  logic [HR_W-1:0]  load_hr,
  output logic [MIN_W-1:0] minutes,
  output logic [HR_W-1:0]  hours,
  output logic [3:0]       hours_12,
  output logic             pm,
  output logic             tick_hour,
  output logic             tick_day,
  output logic             load_err
);
  import clock_pkg::*;

  localparam logic [MIN_W-1:0] MIN_LAST = MIN_W'(MIN_MAX);
  localparam logic [HR_W-1:0]  HR_LAST  = HR_W'(HR_MAX);

  logic load_ok;
  logic load_bad;
  logic do_count;

  // Classify the request: a valid preset wins over counting, an invalid one
  // is only flagged and lets a coincident tick through.
  always_comb begin
    load_ok  = load && (load_min <= MIN_LAST) && (load_hr <= HR_LAST);
    load_bad = load && !load_ok;
    do_count = tick_minute && count_en && !load_ok;
  end

  // Time registers and one-cycle carry/error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      minutes   <= '0;
      hours     <= '0;
      tick_hour <= 1'b0;
      tick_day  <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values; pulses default low so they last one cycle.
      tick_hour <= 1'b0;
      tick_day  <= 1'b0;
      load_err  <= load_bad;
      if (load_ok) begin
        minutes <= load_min;
        hours   <= load_hr;
      end else if (do_count) begin
        if (minutes == MIN_LAST) begin
          minutes   <= '0;
          tick_hour <= 1'b1;
          if (hours == HR_LAST) begin
            hours    <= '0;
            tick_day <= 1'b1;
          end else begin
            hours <= hours + 1'b1;
          end
        end else begin
          minutes <= minutes + 1'b1;
        end
      end
    end
  end

  hour_fmt_12h #(
    .HR_W (HR_W)
  ) u_hour_fmt_12h (
    .hours    (hours),
    .hours_12 (hours_12),
    .pm       (pm)
  );

endmodule : minutes_hours_counter
